// File: rtl/avmm_rd_pkg.sv
// avmm_rd_pkg: shared line constants, FSM states and burst-size helper for the burst read master
package avmm_rd_pkg;
  localparam int LINE_BYTES = 64;
  localparam int LINE_SHIFT = 6;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  function automatic logic [63:0] min3(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [63:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction
endpackage

// File: rtl/avmm_rd_resp_fifo.sv
// avmm_rd_resp_fifo: show-ahead response FIFO; head entry is visible on rdata whenever not empty
module avmm_rd_resp_fifo #(
  parameter int DATA_W = 512,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/avmm_burst_read_master.sv
// avmm_burst_read_master: splits a line-count read command into boundary-safe Avalon-MM bursts,
// issuing only while the response FIFO has room reserved for every outstanding line
module avmm_burst_read_master
  import avmm_rd_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int BURST_W = 5,
  parameter int MAX_BURST = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W = 32
) (
  input  logic                  kernel_clk,
  input  logic                  kernel_reset_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_lines,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic [BURST_W-1:0]    avm_burstcount,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready
);
  localparam int RW = $clog2(FIFO_DEPTH) + 1;
  localparam int MW = $clog2(MAX_BURST);
  localparam logic [RW:0] DEPTH_L = (RW+1)'(FIFO_DEPTH);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] issue_rem, pop_rem;
  logic [RW-1:0] reserved;
  logic [BURST_W-1:0] blen;
  logic done_q, cmd_acc, req_acc, pop, last_pop, fifo_empty, fifo_full_unused;
  logic [RW-1:0] fifo_count_unused;
  // burst never crosses a MAX_BURST-line boundary: cap by lines left before the next one
  assign blen = BURST_W'(min3(64'(issue_rem), 64'(MAX_BURST), 64'(MAX_BURST) - 64'(addr[LINE_SHIFT +: MW])));
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign done = done_q;
  assign cmd_acc = cmd_valid && cmd_ready;
  // request is held stable while stalled: reserved can only shrink without an accept
  assign avm_read = state == ISSUE && ({1'b0, reserved} + (RW+1)'(blen)) <= DEPTH_L;
  assign avm_address = addr;
  assign avm_burstcount = blen;
  assign avm_byteenable = '1;
  assign req_acc = avm_read && !avm_waitrequest;
  assign out_valid = !fifo_empty;
  assign pop = out_valid && out_ready;
  assign last_pop = pop && pop_rem == LEN_W'(1);
  always_ff @(posedge kernel_clk or negedge kernel_reset_reset_n)
    if (!kernel_reset_reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (cmd_acc && cmd_lines != '0) ? ISSUE : IDLE;
      ISSUE:   state_n = (req_acc && issue_rem == LEN_W'(blen)) ? DRAIN : ISSUE;
      DRAIN:   state_n = last_pop ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge kernel_clk or negedge kernel_reset_reset_n)
    if (!kernel_reset_reset_n) begin
      addr <= '0;
      issue_rem <= '0;
      pop_rem <= '0;
      reserved <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (cmd_acc && cmd_lines == '0) || last_pop;
      reserved <= reserved + (req_acc ? RW'(blen) : '0) - RW'(pop);
      if (cmd_acc) begin
        addr <= cmd_addr & ~ADDR_W'(LINE_BYTES - 1);
        issue_rem <= cmd_lines;
        pop_rem <= cmd_lines;
      end else begin
        if (req_acc) begin
          addr <= addr + (ADDR_W'(blen) << LINE_SHIFT);
          issue_rem <= issue_rem - LEN_W'(blen);
        end
        if (pop) pop_rem <= pop_rem - LEN_W'(1);
      end
    end
  avmm_rd_resp_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(kernel_clk),
    .rst_n(kernel_reset_reset_n),
    .push(avm_readdatavalid),
    .wdata(avm_readdata),
    .pop(pop),
    .rdata(out_data),
    .empty(fifo_empty),
    .full(fifo_full_unused),
    .count(fifo_count_unused)
  );
endmodule

// File: doc/avmm_burst_read_master.md
Name: avmm_burst_read_master

Overview:
- Kernel-side Avalon-MM burst read initiator. It drives the board's host-memory read slave (the avmm_r path toward CCI-P) and returns line data as a valid/ready stream.
- It accepts one command at a time: a 64-byte-aligned base address and a line count. It splits the command into bursts of up to MAX_BURST lines and tracks credits so returned data never overflows the local response FIFO.
- It gives kernel logic and the BSP test infrastructure a reusable reader for host buffers.

Parameters:
DATA_W, 512, line width in bits (one 64-byte line per beat)
ADDR_W, 64, byte address width
BURST_W, 5, burstcount width
MAX_BURST, 16, maximum lines per burst; power of two, at most 2**(BURST_W-1)
FIFO_DEPTH, 64, response FIFO entries; power of two, at least MAX_BURST
LEN_W, 32, command line-count width

Ports:
kernel_clk  in  1  sole clock
kernel_reset_reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_W  byte base address; bits [5:0] are ignored and treated as 0
cmd_lines  in  LEN_W  number of 64-byte lines to read
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse when the last line of a command has been popped
avm_address  out  ADDR_W  burst start byte address
avm_read  out  1  read request
avm_burstcount  out  BURST_W  lines in this burst
avm_byteenable  out  DATA_W/8  constant all ones
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  returned line
avm_readdatavalid  in  1  returned line valid
out_valid  out  1  stream data valid
out_data  out  DATA_W  stream data
out_ready  in  1  stream consumer ready

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, avm_read=0, avm_address=0, avm_burstcount=0, out_valid=0. All counters and the FIFO are cleared.
- Reset is asynchronous in any state, including mid-burst. The whole kernel/board fabric shares this reset, so no stale responses arrive after reset deassertion.
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE:
  - A command is accepted on cmd_valid&&cmd_ready.
  - The block latches addr={cmd_addr[ADDR_W-1:6],6'b0}, issue_rem=cmd_lines and pop_rem=cmd_lines.
  - If cmd_lines==0, done pulses on the next cycle, the FSM stays in IDLE and no reads are issued.
  - Otherwise the FSM goes to ISSUE, and avm_read can assert at the earliest on the cycle after acceptance.
- Burst size:
  - blen = min(issue_rem, MAX_BURST, MAX_BURST - line_index%MAX_BURST), where line_index = addr>>6.
  - No burst crosses a MAX_BURST-line-aligned boundary (1 KB at the defaults).
- Credit rule:
  - reserved = lines issued but not yet popped from the FIFO.
  - avm_read asserts only when reserved + blen <= FIFO_DEPTH.
  - reserved increments by blen on an accepted request (avm_read && !avm_waitrequest).
  - reserved decrements by 1 on a pop (out_valid && out_ready).
  - When an accept and a pop happen in the same cycle, both apply.
  - reserved never exceeds FIFO_DEPTH.
- Request hold: while avm_waitrequest=1, avm_read, avm_address and avm_burstcount stay stable. Once asserted, avm_read is never withdrawn before acceptance.
- On accept: addr += blen*64 and issue_rem -= blen. When issue_rem reaches 0, the FSM goes to DRAIN and avm_read is 0 from the next cycle.
- Responses:
  - Every avm_readdatavalid beat is written to the FIFO.
  - A write to a full FIFO is impossible by the credit rule; the bench asserts on it.
  - out_valid reflects a non-empty FIFO. The latency from avm_readdatavalid to out_valid is 1 cycle.
  - Data order matches request order.
- DRAIN: on the pop that brings pop_rem to 0, done pulses on the following cycle and the FSM returns to IDLE. cmd_ready is 1 in that same cycle, so a back-to-back command can be accepted then.
- Pops can overlap with ISSUE. pop_rem also decrements during ISSUE.
- Arithmetic widths:
  - reserved is $clog2(FIFO_DEPTH)+1 bits.
  - Address increments wrap modulo 2**ADDR_W without any flag.

Decomposition:
- Package avmm_rd_pkg holds:
  - LINE_BYTES=64 and LINE_SHIFT=6
  - the FSM state enum {IDLE, ISSUE, DRAIN}
  - a function min3 for the burst-size calculation
- Sub-module avmm_rd_resp_fifo: a synchronous show-ahead FIFO with DATA_W×FIFO_DEPTH storage, push/pop, and empty/full/count outputs.

Test Plan:
- Aligned multi-burst: addr 0x1000, 40 lines, slave always ready → bursts 16@0x1000, 16@0x1400, 8@0x1800; 40 beats in order; one done pulse.
- Boundary split: addr 0x1380, 5 lines → burst 2@0x1380 then 3@0x1400; an addr 0x13A7 input behaves identically.
- Waitrequest stall: waitrequest held high 7 cycles on the first burst → address and burstcount stable throughout; exactly one burst is counted on release.
- Backpressure: 100 lines with out_ready=0 → bursts stop once reserved=64 (4 bursts); raising out_ready resumes issue; all 100 beats arrive in order and reserved never exceeds 64.
- Zero length, then back-to-back: cmd_lines=0 → done on the next cycle with no avm_read. Then two 16-line commands back to back → the second is accepted in the cycle done pulses for the first.
- Reset mid-operation: assert reset during the second burst of a 40-line command → all outputs go to reset values immediately; a fresh 8-line command after release completes normally.
